// File: rtl/alu_pkg.sv
// Shared opcode encoding and default operand width for the ALU slice.
package alu_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } op_e;

endpackage

// File: rtl/alu_core.sv
// Combinational datapath: next result and, with ALU_FLAGS_EN defined, next status flags.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic [2:0]       operation,
`ifdef ALU_FLAGS_EN
  output logic             carry,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
`endif
  output logic [WIDTH-1:0] result
);

  op_e op;
  assign op = op_e'(operation);

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = operand1 + operand2;
      OP_SUB:  result = operand1 - operand2;
      OP_AND:  result = operand1 & operand2;
      OP_OR:   result = operand1 | operand2;
      OP_XOR:  result = operand1 ^ operand2;
      OP_NOT:  result = ~operand1;
      OP_SHL:  result = {operand1[WIDTH-2:0], 1'b0};
      OP_SHR:  result = {1'b0, operand1[WIDTH-1:1]};
      default: result = '0;
    endcase
  end

`ifdef ALU_FLAGS_EN
  logic a_msb, b_msb, r_msb;
  assign a_msb = operand1[WIDTH-1];
  assign b_msb = operand2[WIDTH-1];
  assign r_msb = result[WIDTH-1];

  // An unsigned add wrapped exactly when the truncated sum is below an addend.
  always_comb begin
    carry    = 1'b0;
    overflow = 1'b0;
    case (op)
      OP_ADD: begin
        carry    = (result < operand1);
        overflow = (a_msb == b_msb) && (r_msb != a_msb);
      end
      OP_SUB: begin
        carry    = (operand1 < operand2);
        overflow = (a_msb != b_msb) && (r_msb != a_msb);
      end
      OP_SHL:  carry = a_msb;
      OP_SHR:  carry = operand1[0];
      default: carry = 1'b0;
    endcase
  end

  assign zero     = (result == '0);
  assign negative = r_msb;
`endif

endmodule

// File: rtl/alu.sv
// Registered ALU with one-cycle latency; status flag ports exist only when ALU_FLAGS_EN is defined.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic [2:0]       operation,
`ifdef ALU_FLAGS_EN
  output logic             carry,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
`endif
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] result_next;

`ifdef ALU_FLAGS_EN
  logic carry_next, zero_next, negative_next, overflow_next;
`endif

  alu_core #(.WIDTH(WIDTH)) u_core (
    .operand1  (operand1),
    .operand2  (operand2),
    .operation (operation),
`ifdef ALU_FLAGS_EN
    .carry     (carry_next),
    .zero      (zero_next),
    .negative  (negative_next),
    .overflow  (overflow_next),
`endif
    .result    (result_next)
  );

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      result <= '0;
    end else if (enable) begin
      result <= result_next;
    end
  end

`ifdef ALU_FLAGS_EN
  // Reset leaves the flags describing a zero result.
  always_ff @(posedge clk) begin
    if (reset) begin
      carry    <= 1'b0;
      zero     <= 1'b1;
      negative <= 1'b0;
      overflow <= 1'b0;
    end else if (enable) begin
      carry    <= carry_next;
      zero     <= zero_next;
      negative <= negative_next;
      overflow <= overflow_next;
    end
  end
`endif

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, hold/reset sequences, random vs. reference model.
module tb_alu;
  import alu_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [W-1:0] operand1;
  logic [W-1:0] operand2;
  logic [2:0]   operation;
  logic [W-1:0] result;
`ifdef ALU_FLAGS_EN
  logic carry, zero, negative, overflow;
`endif

  alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .operand1  (operand1),
    .operand2  (operand2),
    .operation (operation),
`ifdef ALU_FLAGS_EN
    .carry     (carry),
    .zero      (zero),
    .negative  (negative),
    .overflow  (overflow),
`endif
    .result    (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       c;
    logic       z;
    logic       n;
    logic       v;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [7:0] r, input logic c,
                             input logic z, input logic n, input logic v);
    check({tag, ".result"}, 32'(result), 32'(r));
`ifdef ALU_FLAGS_EN
    check({tag, ".carry"},    32'(carry),    32'(c));
    check({tag, ".zero"},     32'(zero),     32'(z));
    check({tag, ".negative"}, 32'(negative), 32'(n));
    check({tag, ".overflow"}, 32'(overflow), 32'(v));
`endif
  endtask

  // Drive before the edge, sample 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model from the arithmetic definitions, using signed/unsigned integers.
  function automatic vec_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    vec_t m;
    int ua, ub, sa, sb, full, sfull;
    ua = int'(a); ub = int'(b);
    sa = (ua > 127) ? ua - 256 : ua;
    sb = (ub > 127) ? ub - 256 : ub;
    m.op = op; m.a = a; m.b = b; m.c = 1'b0; m.v = 1'b0;
    full = 0;
    case (op)
      3'd0: begin full = ua + ub; m.c = (full > 255); sfull = sa + sb; m.v = (sfull > 127 || sfull < -128); end
      3'd1: begin full = ua - ub + 256; m.c = (ua < ub); sfull = sa - sb; m.v = (sfull > 127 || sfull < -128); end
      3'd2: full = int'(a & b);
      3'd3: full = int'(a | b);
      3'd4: full = int'(a ^ b);
      3'd5: full = 255 - ua;
      3'd6: begin full = ua * 2; m.c = (ua >= 128); end
      default: begin full = ua / 2; m.c = (ua % 2 == 1); end
    endcase
    m.res = 8'(full % 256);
    m.z = (m.res == 8'h00);
    m.n = (m.res >= 8'h80);
    return m;
  endfunction

  vec_t vecs[15];
  vec_t exp_s;

  initial begin
    vecs[0]  = '{OP_ADD, 8'h0D, 8'h03, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{OP_SUB, 8'h0D, 8'h03, 8'h0A, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{OP_AND, 8'h0D, 8'h03, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{OP_OR,  8'h0D, 8'h03, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{OP_XOR, 8'h0D, 8'h03, 8'h0E, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{OP_NOT, 8'h0D, 8'h03, 8'hF2, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{OP_SHL, 8'h0D, 8'h03, 8'h1A, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{OP_SHR, 8'h0D, 8'h03, 8'h06, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{OP_SUB, 8'h03, 8'h0D, 8'hF6, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{OP_SUB, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{OP_SHL, 8'h80, 8'h55, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{OP_SHR, 8'h01, 8'hAA, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{OP_NOT, 8'hF0, 8'hFF, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0};

    reset = 1'b1; enable = 1'b0; operand1 = '0; operand2 = '0; operation = OP_ADD;
    step();
    check_state("reset", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

    reset = 1'b0; enable = 1'b1;
    for (int i = 0; i < 15; i++) begin
      operation = vecs[i].op; operand1 = vecs[i].a; operand2 = vecs[i].b;
      step();
      check_state($sformatf("vec%0d", i), vecs[i].res, vecs[i].c, vecs[i].z, vecs[i].n, vecs[i].v);
    end

    // Hold: operands change with enable low, outputs keep the last vector.
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      operation = OP_ADD; operand1 = 8'(8'h11 * (i + 1)); operand2 = 8'h22;
      step();
      check_state($sformatf("hold%0d", i), 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Reset wins over enable, then the first enabled cycle is a normal result.
    enable = 1'b1; operation = OP_SUB; operand1 = 8'h05; operand2 = 8'h09;
    step();
    check_state("pre_rst", 8'hFC, 1'b1, 1'b0, 1'b1, 1'b0);
    reset = 1'b1; operation = OP_ADD; operand1 = 8'h05; operand2 = 8'h05;
    step();
    check_state("rst_en", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    step();
    check_state("post_rst", 8'h0A, 1'b0, 1'b0, 1'b0, 1'b0);

    // Random traffic with occasional reset and idle cycles.
    exp_s = model(3'd0, 8'h05, 8'h05);
    for (int i = 0; i < 300; i++) begin
      reset     = ($urandom_range(0, 19) == 0);
      enable    = ($urandom_range(0, 3) != 0);
      operation = 3'($urandom_range(0, 7));
      operand1  = 8'($urandom);
      operand2  = 8'($urandom);
      if (reset) begin
        exp_s = model(3'd2, 8'h00, 8'h00);
      end else if (enable) begin
        exp_s = model(operation, operand1, operand2);
      end
      step();
      check_state($sformatf("rnd%0d_op%0d_%02h_%02h", i, operation, operand1, operand2),
                  exp_s.res, exp_s.c, exp_s.z, exp_s.n, exp_s.v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
